// File: rtl/sfp_pkg.sv
// Shared definitions for the special-function row normaliser: widths,
// lane packing helpers and the signed-magnitude fixed-point divide.
package sfp_pkg;

    localparam int BW_PSUM = 20;
    localparam int COL     = 8;
    localparam int FRAC    = 8;
    localparam int DEPTH   = 16;

    // Sum of COL lanes of (BW_PSUM+1)-bit magnitudes cannot exceed BW_PSUM+4 bits.
    localparam int SUM_W = BW_PSUM + 4;
    localparam int ABS_W = BW_PSUM + 1;
    localparam int NUM_W = ABS_W + FRAC;

    typedef logic [BW_PSUM-1:0]     lane_t;
    typedef logic [COL*BW_PSUM-1:0] row_t;
    typedef logic [ABS_W-1:0]       abs_t;
    typedef logic [SUM_W-1:0]       sum_t;

    // Extract lane idx from a packed row.
    function automatic lane_t get_lane(input row_t row, input int unsigned idx);
        return row[idx*BW_PSUM +: BW_PSUM];
    endfunction

    // Return row with lane idx replaced by val.
    function automatic row_t set_lane(input row_t row, input int unsigned idx, input lane_t val);
        row_t r;
        r = row;
        r[idx*BW_PSUM +: BW_PSUM] = val;
        return r;
    endfunction

    // One extra bit keeps the most negative lane value exact.
    function automatic abs_t lane_abs(input lane_t x);
        abs_t ext;
        ext = {x[BW_PSUM-1], x};
        return x[BW_PSUM-1] ? abs_t'(-ext) : ext;
    endfunction

    // floor((|x| << shift) / s) with the sign of x reapplied; s == 0 yields 0.
    // |x| <= s always holds, so the quotient magnitude is at most 2^shift.
    function automatic lane_t sfp_div(input lane_t x, input sum_t s, input int unsigned shift);
        logic [NUM_W-1:0] num;
        logic [NUM_W-1:0] quo;
        num = NUM_W'(lane_abs(x)) << shift;
        if (s == '0) begin
            return '0;
        end
        quo = num / NUM_W'(s);
        return x[BW_PSUM-1] ? lane_t'(-quo) : lane_t'(quo);
    endfunction

endpackage

// File: rtl/sfp_sum_fifo.sv
// Row-sum FIFO: synchronous push/pop, registered full/empty flags,
// simultaneous push and pop honoured even when full.
module sfp_sum_fifo #(
    parameter int width = 24,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage array write port.
    // NOTE: the data array has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered status flags; pointers wrap naturally at depth.
    // NOTE: all state here uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (PTR_W+1)'(depth));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/sfp_row_norm.sv
// Row normaliser: accumulate phase queues per-row sums of |lane|,
// divide phase scales each lane by its row's queued sum.
module sfp_row_norm
    import sfp_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int col     = COL,
    parameter int frac    = FRAC,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acc,
    input  logic                   div,
    input  logic                   fifo_ext_rd,
    input  logic [col*bw_psum-1:0] in_data,
    output logic [col*bw_psum-1:0] sfp_out,
    output logic                   out_valid,
    output logic [bw_psum+3:0]     sum_out,
    output logic                   sum_valid,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   err_ovf,
    output logic                   err_udf,
    output logic                   err_cmd
);

    // Accumulate pipeline
    abs_t abs_q [col];
    logic acc_v;
    sum_t row_sum;

    // Divide pipeline
    logic d_v;
    row_t d_row;
    sum_t d_sum;
    row_t quo_row;

    // FIFO interface
    sum_t head;
    logic div_go;
    logic pop_req;
    logic pop_ok;

    // A colliding div is dropped in favour of acc; either consumer may pop.
    assign div_go  = div && !acc;
    assign pop_req = div_go || fifo_ext_rd;
    assign pop_ok  = pop_req && !fifo_empty;

    // Stage 1 of accumulate: register per-lane magnitudes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_v <= 1'b0;
            for (int i = 0; i < col; i++) abs_q[i] <= '0;
        end else begin
            acc_v <= acc;
            if (acc) begin
                for (int i = 0; i < col; i++) abs_q[i] <= lane_abs(get_lane(in_data, i));
            end
        end
    end

    // Adder tree over the registered magnitudes; the result is the push data.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < col; i++) row_sum = row_sum + SUM_W'(abs_q[i]);
    end

    sfp_sum_fifo #(
        .width (SUM_W),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (acc_v),
        .pop   (pop_req),
        .wdata (row_sum),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stage 1 of divide: capture the row and the FIFO head (zero on underflow).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_v   <= 1'b0;
            d_row <= '0;
            d_sum <= '0;
        end else begin
            d_v <= div_go;
            if (div_go) begin
                d_row <= in_data;
                d_sum <= fifo_empty ? '0 : head;
            end
        end
    end

    // Per-lane fixed-point ratio of the captured row.
    always_comb begin
        quo_row = '0;
        for (int i = 0; i < col; i++) begin
            quo_row = set_lane(quo_row, i, sfp_div(get_lane(d_row, i), d_sum, frac));
        end
    end

    // Stage 2 of divide: register quotients and the output strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfp_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= d_v;
            if (d_v) sfp_out <= quo_row;
        end
    end

    // External pop port: sum_out holds its last value unless a real pop occurs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= fifo_ext_rd && !fifo_empty;
            if (fifo_ext_rd && !fifo_empty) sum_out <= head;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            if (acc_v && fifo_full && !pop_ok) err_ovf <= 1'b1;
            if (pop_req && fifo_empty)         err_udf <= 1'b1;
            if (acc && div)                    err_cmd <= 1'b1;
        end
    end

endmodule
